// File: rtl/regfile_param.sv
// Parameterized register file: CLEAR-sweep/RUN FSM, combinational read ports, hardwired zero register.
// Optional same-cycle write-to-read forwarding under macro RF_BYPASS_EN.

module regfile_param_rdport #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] rdata
);
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  always_comb begin
    rdata = '0;
    if (ready && (raddr != ZR)) rdata = rword;
  end
endmodule

module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] Rn,
  input  logic [ADDR_W-1:0] Rm,
  input  logic [ADDR_W-1:0] Rd,
  input  logic              RegWr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              ready
);
  localparam int              DEPTH  = 2**ADDR_W;
  localparam int              NUM_RD = 2;
  localparam logic [ADDR_W-1:0] ZR   = ADDR_W'(ZERO_REG);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wr_fire;

  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rword;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        // cnt wraps to 0 on the same edge that enters RUN
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready   = ready_q;
  assign wr_fire = ready_q && RegWr && !clr && (Rd != ZR);

  always_comb begin
    mem_we    = wr_fire;
    mem_waddr = Rd;
    mem_wdata = data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end
  end

  // Storage has no reset; the CLEAR sweep zeroes it
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign raddr = {Rm, Rn};

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
`ifdef RF_BYPASS_EN
    assign rword[i] = (wr_fire && (raddr[i] == Rd)) ? data : mem_q[raddr[i]];
`else
    assign rword[i] = mem_q[raddr[i]];
`endif
    regfile_param_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .ready(ready_q),
      .raddr(raddr[i]),
      .rword(rword[i]),
      .rdata(rdata[i])
    );
  end

  assign out1 = rdata[0];
  assign out2 = rdata[1];
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default parameters), scoreboard-driven read checks.
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic [4:0]  Rn = '0, Rm = '0, Rd = '0;
  logic        RegWr = 1'b0;
  logic [63:0] data = '0;
  logic [63:0] out1, out2;
  logic        ready;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  regfile_param dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .Rn(Rn), .Rm(Rm), .Rd(Rd),
    .RegWr(RegWr), .data(data), .out1(out1), .out2(out2), .ready(ready)
  );

  always #5 clk = ~clk;

  task step;
    @(posedge clk); #1;
  endtask

  task do_write(input logic [4:0] a, input logic [63:0] d);
    Rd = a; data = d; RegWr = 1'b1;
    step;
    RegWr = 1'b0;
  endtask

  task test_reset;
    #2 rst_n = 1'b0;
    Rn = 5'd5; Rm = 5'd31;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL rst_out1 got=%h exp=%h", out1, e); end
    e = exp_q.pop_front();
    total++; if (out2 !== e) begin bad++; $display("FAIL rst_out2 got=%h exp=%h", out2, e); end
    step; step;
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      Rn = 5'(k); Rm = 5'(k + 3);
      step;
      total++;
      if (ready !== (k == 32)) begin bad++; $display("FAIL sweep_ready k=%0d got=%b exp=%b", k, ready, (k == 32)); end
      if (k < 32) begin
        total++; if (out1 !== 64'h0) begin bad++; $display("FAIL sweep_out1 k=%0d got=%h exp=0", k, out1); end
      end
    end
    for (int i = 0; i < 32; i++) begin
      Rn = 5'(i); Rm = 5'(31 - i);
      exp_q.push_back(64'h0); exp_q.push_back(64'h0);
      #1;
      e = exp_q.pop_front();
      total++; if (out1 !== e) begin bad++; $display("FAIL init_out1 r=%0d got=%h exp=%h", i, out1, e); end
      e = exp_q.pop_front();
      total++; if (out2 !== e) begin bad++; $display("FAIL init_out2 r=%0d got=%h exp=%h", 31 - i, out2, e); end
    end
  endtask

  task test_write_read;
    logic [63:0] v;
    do_write(5'd5, 64'hDEADBEEF);
    Rn = 5'd5; exp_q.push_back(64'hDEADBEEF); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL wr_r5 got=%h exp=%h", out1, e); end
    do_write(5'd31, 64'h1234);
    Rm = 5'd31; exp_q.push_back(64'h0); #1;
    e = exp_q.pop_front();
    total++; if (out2 !== e) begin bad++; $display("FAIL wr_r31 got=%h exp=%h", out2, e); end
    for (int i = 0; i < 5; i++) begin
      v = (i == 4) ? '1 : (64'hA5A5_0000_0000_0000 | (64'(i) << (i * 8)) | 64'h11);
      do_write(5'(i), v);
    end
    for (int i = 0; i < 5; i++) begin
      v = (i == 4) ? '1 : (64'hA5A5_0000_0000_0000 | (64'(i) << (i * 8)) | 64'h11);
      Rn = 5'(i); Rm = 5'(i);
      exp_q.push_back(v); exp_q.push_back(v);
      #1;
      e = exp_q.pop_front();
      total++; if (out1 !== e) begin bad++; $display("FAIL pat_out1 r=%0d got=%h exp=%h", i, out1, e); end
      e = exp_q.pop_front();
      total++; if (out2 !== e) begin bad++; $display("FAIL pat_out2 r=%0d got=%h exp=%h", i, out2, e); end
    end
  endtask

  task test_bypass;
    Rd = 5'd7; data = 64'hAA; RegWr = 1'b1; Rn = 5'd7; Rm = 5'd7;
`ifdef RF_BYPASS_EN
    exp_q.push_back(64'hAA); exp_q.push_back(64'hAA);
`else
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
`endif
    #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL byp_out1 got=%h exp=%h", out1, e); end
    e = exp_q.pop_front();
    total++; if (out2 !== e) begin bad++; $display("FAIL byp_out2 got=%h exp=%h", out2, e); end
    step;
    RegWr = 1'b0;
    exp_q.push_back(64'hAA); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL byp_after got=%h exp=%h", out1, e); end
    Rd = 5'd31; data = 64'h5A5A; RegWr = 1'b1; Rn = 5'd31;
    exp_q.push_back(64'h0); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL byp_zr got=%h exp=%h", out1, e); end
    step;
    RegWr = 1'b0;
  endtask

  task test_clr;
    do_write(5'd3, 64'h77);
    Rn = 5'd3; exp_q.push_back(64'h77); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL clr_pre got=%h exp=%h", out1, e); end
    clr = 1'b1; RegWr = 1'b1; Rd = 5'd3; data = 64'h55;
    exp_q.push_back(64'h77); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL clr_same got=%h exp=%h", out1, e); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL clr_ready_pre got=%b exp=1", ready); end
    step;
    clr = 1'b0; RegWr = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL clr_ready_drop got=%b exp=0", ready); end
    for (int k = 1; k <= 32; k++) begin
      step;
      total++;
      if (ready !== (k == 32)) begin bad++; $display("FAIL clr_sweep k=%0d got=%b exp=%b", k, ready, (k == 32)); end
    end
    exp_q.push_back(64'h0); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL clr_r3 got=%h exp=%h", out1, e); end
  endtask

  task test_mid_reset;
    do_write(5'd9, 64'h1234_5678_9ABC_DEF0);
    clr = 1'b1; step; clr = 1'b0;
    for (int k = 1; k <= 10; k++) step;
    rst_n = 1'b0; Rn = 5'd9; #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mrst_ready got=%b exp=0", ready); end
    total++; if (out1 !== 64'h0) begin bad++; $display("FAIL mrst_out1 got=%h exp=0", out1); end
    step; step;
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step;
      total++;
      if (ready !== (k == 32)) begin bad++; $display("FAIL mrst_sweep k=%0d got=%b exp=%b", k, ready, (k == 32)); end
    end
    do_write(5'd10, 64'hCAFE);
    Rn = 5'd10; exp_q.push_back(64'hCAFE); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL run_r10 got=%h exp=%h", out1, e); end
    rst_n = 1'b0; #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rrst_ready got=%b exp=0", ready); end
    step;
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step;
      total++;
      if (ready !== (k == 32)) begin bad++; $display("FAIL rrst_sweep k=%0d got=%b exp=%b", k, ready, (k == 32)); end
    end
    exp_q.push_back(64'h0); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL rrst_r10 got=%h exp=%h", out1, e); end
  endtask

  task test_write_not_ready;
    clr = 1'b1; step; clr = 1'b0;
    RegWr = 1'b1; Rd = 5'd2; data = 64'h99;
    for (int k = 1; k <= 32; k++) begin
      step;
      if (k == 32) RegWr = 1'b0;
      total++;
      if (ready !== (k == 32)) begin bad++; $display("FAIL nr_sweep k=%0d got=%b exp=%b", k, ready, (k == 32)); end
    end
    Rn = 5'd2; Rm = 5'd2;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); #1;
    e = exp_q.pop_front();
    total++; if (out1 !== e) begin bad++; $display("FAIL nr_r2_out1 got=%h exp=%h", out1, e); end
    e = exp_q.pop_front();
    total++; if (out2 !== e) begin bad++; $display("FAIL nr_r2_out2 got=%h exp=%h", out2, e); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_bypass;
    test_clr;
    test_mid_reset;
    test_write_not_ready;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 31, index hardwired to zero.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous request to re-clear the whole array.
REQ-007 SHALL have port Rn  input  ADDR_W  read address, port 1.
REQ-008 SHALL have port Rm  input  ADDR_W  read address, port 2.
REQ-009 SHALL have port Rd  input  ADDR_W  write address.
REQ-010 SHALL have port RegWr  input  1  write enable.
REQ-011 SHALL have port data  input  DATA_W  write data.
REQ-012 SHALL have port out1  output  DATA_W  read data for Rn.
REQ-013 SHALL have port out2  output  DATA_W  read data for Rm.
REQ-014 SHALL have port ready  output  1  high when array is cleared and writes are accepted.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR, SHALL write 0 to entry cnt on each clock and increment an ADDR_W-bit counter cnt from 0.
REQ-017 SHALL go from CLEAR to RUN on the clock edge that clears entry DEPTH-1, so the sweep takes exactly DEPTH cycles.
REQ-018 In RUN, clr=1 SHALL go to CLEAR with cnt=0 on the next edge.
REQ-019 ready SHALL be 1 only in RUN.
REQ-020 In RUN, RegWr=1 with Rd!=ZERO_REG SHALL write data to entry Rd at the clock edge.
REQ-021 A write with Rd==ZERO_REG SHALL be dropped silently.
REQ-022 RegWr while ready=0 SHALL be dropped, with no write queued for later.
REQ-023 RegWr and clr asserted in the same RUN cycle: clr SHALL win and the write SHALL be dropped.
REQ-024 out1 and out2 SHALL be combinational from Rn/Rm and the array contents, with zero-cycle latency.
REQ-025 A read of ZERO_REG SHALL return 0 in every state.
REQ-026 While ready=0, out1 and out2 SHALL return 0 for every address.
REQ-027 The cnt wrap from DEPTH-1 to 0 SHALL coincide with entry into RUN, with no extra cycle added.
REQ-028 Rn==Rm SHALL return identical data on both ports.

Reset
REQ-029 rst_n low SHALL immediately force state=CLEAR, cnt=0 and ready=0, independent of clk.
REQ-030 The array itself SHALL have no reset; it is zeroed by the CLEAR sweep after rst_n deasserts.
REQ-031 rst_n asserted mid-sweep or mid-RUN SHALL restart the sweep from entry 0.
REQ-032 While rst_n is low, out1 and out2 SHALL be 0 and ready SHALL be 0.

Configuration
REQ-033 SHALL use macro RF_BYPASS_EN.
REQ-034 With RF_BYPASS_EN defined: in RUN, when RegWr=1, Rd!=ZERO_REG, clr=0 and Rn (or Rm) == Rd, out1 (or out2) SHALL return data combinationally in the same cycle.
REQ-035 With RF_BYPASS_EN undefined: out1/out2 SHALL return the pre-write value until after the write edge.

Verification
REQ-036 Reset release with DATA_W=64, ADDR_W=5 -> ready=0 for exactly 32 cycles, then 1; every read returns 0.
REQ-037 Write Rd=5, data=0xDEADBEEF, then Rn=5 next cycle -> out1=0xDEADBEEF; write Rd=31, data=0x1234 -> Rm=31 reads 0.
REQ-038 Same-cycle RegWr (Rd=7, data=0xAA) with Rn=7 -> out1=0xAA if RF_BYPASS_EN, old value (0) otherwise.
REQ-039 clr and RegWr (Rd=3, data=0x55) in the same cycle -> write dropped, ready low 32 cycles, then R3 reads 0.
REQ-040 rst_n pulsed low at sweep cycle 10 -> ready=0 immediately; full 32-cycle sweep restarts after release.
REQ-041 RegWr (Rd=2, data=0x99) while ready=0 -> after ready=1, R2 reads 0.
